// File: rtl/rs_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rs_mem : load reservation station, oldest-ready-first issue by ROB age     |
// | Optional feature macro RS_BYPASS_EN: ready dispatch may issue directly.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

package rs_mem_pkg;
  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [31:0] imm;
    logic [4:0]  rob_index;
    logic [6:0]  ps1;
    logic [6:0]  pd;
  } rs_data;
endpackage

module rs_mem
  import rs_mem_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int ROB_SIZE = 16,
  parameter int NUM_CDB  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 disp_valid,
  input  rs_data               disp_data,
  input  logic                 disp_ps1_rdy,
  output logic                 rs_full,
  input  logic [NUM_CDB-1:0]   cdb_valid,
  input  logic [NUM_CDB*7-1:0] cdb_tag,
  input  logic                 fu_mem_ready,
  input  logic [4:0]           rob_head,
  input  logic [4:0]           curr_rob_tag,
  input  logic                 mispredict,
  input  logic [4:0]           mispredict_tag,
  output logic                 issued,
  output rs_data               data_out,
  output logic [6:0]           ps1_out,
  output logic [6:0]           pd_out
);

  localparam int               IDX_W      = $clog2(DEPTH);
  localparam int               CNT_W      = IDX_W + 1;
  localparam logic [4:0]       C_AGE_MASK = 5'(ROB_SIZE - 1);
  localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(DEPTH);

  // Physical register 0 is hard-wired, so it counts as a permanent hit.
  function automatic logic cdb_hit(input logic [6:0]           tag,
                                   input logic [NUM_CDB-1:0]   vld,
                                   input logic [NUM_CDB*7-1:0] tags);
    logic hit;
    hit = (tag == 7'd0);
    for (int k = 0; k < NUM_CDB; k++) begin
      if (vld[k] && (tags[k*7 +: 7] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [4:0] age_of(input logic [4:0] idx, input logic [4:0] base);
    return (idx - base) & C_AGE_MASK;
  endfunction

  // Wrong-path window is (branch+1 .. tail-1); an empty window has length 0.
  function automatic logic in_flush(input logic [4:0] idx,
                                    input logic [4:0] br_tag,
                                    input logic [4:0] tail);
    logic [4:0] first;
    first = br_tag + 5'd1;
    return age_of(idx, first) < age_of(tail, first);
  endfunction

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] rdy_q, rdy_d;
  rs_data           ent_q [DEPTH];
  rs_data           ent_d [DEPTH];
  logic             issued_q, issued_d;
  rs_data           data_out_q, data_out_d;

  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] free_idx;
  logic             cand_found;
  logic [IDX_W-1:0] sel_idx;
  logic [4:0]       sel_age;

  always_comb begin
    count      = '0;
    free_idx   = '0;
    cand_found = 1'b0;
    sel_idx    = '0;
    sel_age    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i]) count = count + CNT_W'(1);
      else            free_idx = IDX_W'(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && rdy_q[i] &&
          (!cand_found || (age_of(ent_q[i].rob_index, rob_head) < sel_age))) begin
        cand_found = 1'b1;
        sel_idx    = IDX_W'(i);
        sel_age    = age_of(ent_q[i].rob_index, rob_head);
      end
    end
  end

  assign rs_full = (count == C_DEPTH);

  logic disp_rdy;
  logic disp_ok;
  logic bypass;
  logic do_issue;

  always_comb begin
    valid_d    = valid_q;
    rdy_d      = rdy_q;
    ent_d      = ent_q;
    issued_d   = 1'b0;
    data_out_d = data_out_q;

    disp_rdy = disp_ps1_rdy || cdb_hit(disp_data.ps1, cdb_valid, cdb_tag);
    disp_ok  = disp_valid && !rs_full &&
               !(mispredict && in_flush(disp_data.rob_index, mispredict_tag, curr_rob_tag));
`ifdef RS_BYPASS_EN
    bypass   = disp_ok && disp_rdy && fu_mem_ready && !mispredict &&
               (!cand_found || (age_of(disp_data.rob_index, rob_head) < sel_age));
`else
    bypass   = 1'b0;
`endif
    do_issue = fu_mem_ready && cand_found && !mispredict && !bypass;

    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && cdb_hit(ent_q[i].ps1, cdb_valid, cdb_tag)) rdy_d[i] = 1'b1;
      if (mispredict && in_flush(ent_q[i].rob_index, mispredict_tag, curr_rob_tag))
        valid_d[i] = 1'b0;
    end

    if (do_issue) begin
      valid_d[sel_idx] = 1'b0;
      issued_d         = 1'b1;
      data_out_d       = ent_q[sel_idx];
    end

    if (bypass) begin
      issued_d   = 1'b1;
      data_out_d = disp_data;
    end else if (disp_ok) begin
      valid_d[free_idx] = 1'b1;
      rdy_d[free_idx]   = disp_rdy;
      ent_d[free_idx]   = disp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      rdy_q      <= '0;
      issued_q   <= 1'b0;
      data_out_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      valid_q    <= valid_d;
      rdy_q      <= rdy_d;
      issued_q   <= issued_d;
      data_out_q <= data_out_d;
      ent_q      <= ent_d;
    end
  end

  assign issued   = issued_q;
  assign data_out = data_out_q;
  assign ps1_out  = data_out_q.ps1;
  assign pd_out   = data_out_q.pd;

endmodule
`default_nettype wire

// File: tb/tb_rs_mem.sv
`default_nettype none
// tb_rs_mem : directed stimulus with a scoreboard queue checked by an issue monitor.
module tb_rs_mem;
  import rs_mem_pkg::*;

`ifdef RS_BYPASS_EN
  localparam int DISP_LAT = 1;
`else
  localparam int DISP_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        disp_valid;
  rs_data      disp_data;
  logic        disp_ps1_rdy;
  logic        rs_full;
  logic [2:0]  cdb_valid;
  logic [20:0] cdb_tag;
  logic        fu_mem_ready;
  logic [4:0]  rob_head;
  logic [4:0]  curr_rob_tag;
  logic        mispredict;
  logic [4:0]  mispredict_tag;
  logic        issued;
  rs_data      data_out;
  logic [6:0]  ps1_out;
  logic [6:0]  pd_out;

  rs_mem #(.DEPTH(8), .ROB_SIZE(16), .NUM_CDB(3)) dut (
    .clk(clk), .reset(reset), .disp_valid(disp_valid), .disp_data(disp_data),
    .disp_ps1_rdy(disp_ps1_rdy), .rs_full(rs_full), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .fu_mem_ready(fu_mem_ready), .rob_head(rob_head),
    .curr_rob_tag(curr_rob_tag), .mispredict(mispredict),
    .mispredict_tag(mispredict_tag), .issued(issued), .data_out(data_out),
    .ps1_out(ps1_out), .pd_out(pd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rob;
    logic [6:0]  ps1;
    logic [6:0]  pd;
    logic [31:0] imm;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (issued === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: rob_index=%0d issued, none expected", data_out.rob_index);
      end else begin
        mon_e = exp_q.pop_front();
        check("issue_rob", 32'(data_out.rob_index), 32'(mon_e.rob));
        check("issue_ps1", 32'(ps1_out), 32'(mon_e.ps1));
        check("issue_pd",  32'(pd_out),  32'(mon_e.pd));
        check("issue_imm", data_out.imm, mon_e.imm);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic expect_issue(input logic [4:0] rob, input logic [6:0] ps1,
                              input logic [6:0] pd, input logic [31:0] imm_v);
    exp_t e;
    e.rob = rob; e.ps1 = ps1; e.pd = pd; e.imm = imm_v;
    exp_q.push_back(e);
  endtask

  // Presents one load for a single cycle, then returns just after the edge.
  task automatic dispatch(input logic [4:0] rob, input logic [6:0] ps1,
                          input logic [6:0] pd, input logic [31:0] imm_v, input logic rdy);
    disp_valid   = 1'b1;
    disp_data    = '{opcode: 7'h03, func3: 3'd2, imm: imm_v, rob_index: rob, ps1: ps1, pd: pd};
    disp_ps1_rdy = rdy;
    tick();
    disp_valid   = 1'b0;
    disp_ps1_rdy = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    @(negedge clk);
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; disp_valid = 1'b0; disp_data = '0; disp_ps1_rdy = 1'b0;
    cdb_valid = '0; cdb_tag = '0; fu_mem_ready = 1'b0; rob_head = 5'd0;
    curr_rob_tag = 5'd0; mispredict = 1'b0; mispredict_tag = 5'd0;
    do_reset();

    @(negedge clk);
    check("reset_issued", 32'(issued), 32'd0);
    check("reset_rs_full", 32'(rs_full), 32'd0);
    check("reset_data_out_zero", 32'(data_out == '0), 32'd1);
    check("reset_ps1_out", 32'(ps1_out), 32'd0);
    check("reset_pd_out", 32'(pd_out), 32'd0);

    // Single ready load: latency from dispatch to issued strobe.
    tick();
    rob_head = 5'd0; curr_rob_tag = 5'd4; fu_mem_ready = 1'b1;
    expect_issue(5'd3, 7'd12, 7'd33, 32'd8);
    dispatch(5'd3, 7'd12, 7'd33, 32'd8, 1'b1);
    for (int c = 1; c <= DISP_LAT; c++) begin
      if (c > 1) tick();
      @(negedge clk);
      check("single_latency", 32'(issued), 32'(c == DISP_LAT));
    end
    wait_drain(5);

    // Fill all entries with unready operands, then wake only rob 5.
    tick();
    curr_rob_tag = 5'd9;
    for (int i = 0; i < 8; i++)
      dispatch(5'(i), 7'(40 + i), 7'(60 + i), 32'(i), 1'b0);
    @(negedge clk);
    check("full_after_8", 32'(rs_full), 32'd1);
    tick();
    dispatch(5'd8, 7'd0, 7'd70, 32'd99, 1'b1);
    @(negedge clk);
    check("full_after_9th", 32'(rs_full), 32'd1);
    tick();
    expect_issue(5'd5, 7'd45, 7'd65, 32'd5);
    cdb_valid = 3'b010;
    cdb_tag[13:7] = 7'd45;
    tick();
    cdb_valid = '0;
    cdb_tag = '0;
    @(negedge clk);
    check("wake_full_still", 32'(rs_full), 32'd1);
    check("wake_not_yet", 32'(issued), 32'd0);
    tick();
    @(negedge clk);
    check("wake_issued", 32'(issued), 32'd1);
    check("full_dropped", 32'(rs_full), 32'd0);
    wait_drain(5);

    // Wrap-around age with memory unit stalled first.
    do_reset();
    rob_head = 5'd14; curr_rob_tag = 5'd2; fu_mem_ready = 1'b0;
    dispatch(5'd1,  7'd11, 7'd51, 32'h100, 1'b1);
    dispatch(5'd0,  7'd10, 7'd50, 32'h200, 1'b1);
    dispatch(5'd15, 7'd9,  7'd49, 32'h300, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_no_issue", 32'(issued), 32'd0);
      tick();
    end
    expect_issue(5'd15, 7'd9,  7'd49, 32'h300);
    expect_issue(5'd0,  7'd10, 7'd50, 32'h200);
    expect_issue(5'd1,  7'd11, 7'd51, 32'h100);
    fu_mem_ready = 1'b1;
    wait_drain(20);

    // Mispredict squashes rob 4 and 5; rob 2 survives; no issue that cycle.
    do_reset();
    rob_head = 5'd0; curr_rob_tag = 5'd6; fu_mem_ready = 1'b0;
    dispatch(5'd2, 7'd21, 7'd81, 32'd2, 1'b1);
    dispatch(5'd4, 7'd22, 7'd82, 32'd4, 1'b1);
    dispatch(5'd5, 7'd23, 7'd83, 32'd5, 1'b1);
    mispredict = 1'b1; mispredict_tag = 5'd3; fu_mem_ready = 1'b1;
    expect_issue(5'd2, 7'd21, 7'd81, 32'd2);
    dispatch(5'd5, 7'd24, 7'd84, 32'd55, 1'b1);
    mispredict = 1'b0;
    @(negedge clk);
    check("flush_no_issue", 32'(issued), 32'd0);
    wait_drain(10);
    repeat (5) tick();

    // Same-cycle CDB wakeup captured at dispatch.
    do_reset();
    rob_head = 5'd6; curr_rob_tag = 5'd8; fu_mem_ready = 1'b1;
    cdb_valid = 3'b010;
    cdb_tag[13:7] = 7'd20;
    expect_issue(5'd7, 7'd20, 7'd90, 32'd77);
    dispatch(5'd7, 7'd20, 7'd90, 32'd77, 1'b0);
    cdb_valid = '0;
    cdb_tag = '0;
    for (int c = 1; c <= DISP_LAT; c++) begin
      if (c > 1) tick();
      @(negedge clk);
      check("cdb_capture_latency", 32'(issued), 32'(c == DISP_LAT));
    end
    wait_drain(5);

    // Reset during a pending issue cancels it.
    tick();
    fu_mem_ready = 1'b0;
    dispatch(5'd9, 7'd0, 7'd91, 32'd9, 1'b1);
    fu_mem_ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("reset_cancels_issue", 32'(issued), 32'd0);
    check("reset_clears_pd", 32'(pd_out), 32'd0);
    repeat (4) tick();

    @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
